seq_det_scheduler: RTL and testbench
====================================

# seq_det_scheduler

Time-multiplexes one shared serial pattern matcher across NUM_CH independent bit streams. Each channel keeps its own match context: a bit-history shift register, a fill count and a match counter. A round-robin arbiter grants at most one channel per cycle. This block is the controller in front of the team's sequence-detector datapath: it owns configuration of the pattern, arbitration of the shared matcher, and match reporting.

## Interface
Parameters:
- NUM_CH, 4, number of serial input channels (2..16)
- PAT_MAX, 8, maximum pattern length in bits
- CNT_W, 8, width of per-channel match counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request; low parks the block in IDLE
- cfg_we  in  1  pulse: load cfg_pattern/cfg_len, clear all contexts
- cfg_pattern  in  PAT_MAX  pattern; bit 0 = most recent bit
- cfg_len  in  $clog2(PAT_MAX+1)  active pattern length
- in_valid  in  NUM_CH  per-channel bit valid
- in_bit  in  NUM_CH  per-channel serial bit
- in_ready  out  NUM_CH  per-channel accept, one-hot or zero
- match_valid  out  1  registered match strobe
- match_ch  out  $clog2(NUM_CH)  channel that matched
- match_count  out  CNT_W  that channel's counter value after increment
- busy  out  1  high in RUN state

## Operation
- FSM states:
  - IDLE → RUN when enable=1 and cfg_we=0.
  - RUN → IDLE when enable=0.
  - Any state → CLEAR on cfg_we=1.
  - CLEAR lasts one cycle, then goes to RUN if enable=1, else IDLE.
- IDLE and CLEAR: in_ready=0. Contexts hold in IDLE and are zeroed in CLEAR.
- RUN: the arbiter picks the first channel with in_valid=1, starting at rr_ptr. That channel's in_ready=1. A transfer occurs when in_valid & in_ready.
- rr_ptr advances to (granted channel + 1) mod NUM_CH only on a transfer. It is unchanged when there is no request.
- Context update on transfer:
  - hist = {hist[PAT_MAX-2:0], in_bit}.
  - fill = min(fill+1, PAT_MAX).
- Match condition: fill_new ≥ L and hist_new[L-1:0] == pattern[L-1:0], where L is the effective length.
- On a match, the channel counter increments and saturates at 2^CNT_W−1.
- Effective length: cfg_len=0 is treated as 1; cfg_len>PAT_MAX is clamped to PAT_MAX.
- cfg_we while in RUN aborts the current cycle's grant (in_ready=0 that cycle). Any in-flight match strobe for the aborted cycle is suppressed.
- Reset values:
  - State=IDLE, rr_ptr=0.
  - All hist, fill and counters = 0.
  - Pattern=0, length=1.
  - match_valid=0, match_ch=0, match_count=0, in_ready=0, busy=0.

## Timing
- in_ready is combinational from in_valid, rr_ptr and state. There is no combinational path from in_bit to in_ready.
- Match latency: match_valid pulses for exactly one cycle, in the cycle after the accepting edge. match_ch and match_count are valid with it and hold their values otherwise.
- Throughput: one bit per cycle aggregate. A channel that is continuously valid gets at least 1 of every NUM_CH cycles when all channels are valid.
- Back-to-back matches on different channels in consecutive cycles produce consecutive strobes.
- reset asserted mid-operation clears everything immediately, with no pending strobe.

## Configuration
- SEQ_DET_OVERLAP_EN:
  - Defined: overlapping detection. On a match, hist and fill continue unchanged, so the next match can reuse bits.
  - Undefined: non-overlapping. On a match, that channel's fill is cleared to 0, so L new bits are needed before the next match.

## Structure
- seq_det_pkg holds:
  - FSM state enum (IDLE, RUN, CLEAR).
  - Default PAT_MAX/CNT_W constants.
  - Context struct {hist, fill, count}.
- Sub-module seq_det_rr_arbiter:
  - Parameter NUM_CH.
  - Inputs: req, ptr, en.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; rr_ptr is stored in the parent.

## Test plan
- Pattern 101, L=3, overlap on; ch0 streams 1,0,1,0,1 alone → match_valid with match_ch=0 after the 3rd and 5th bits; match_count 1, then 2.
- Same stimulus with the macro undefined → one match only, after the 3rd bit; count=1.
- All 4 channels hold in_valid=1 from reset → grants in order 0,1,2,3,0,…; each channel gets exactly 1 of every 4 cycles.
- ch2 drops in_valid while ch1 and ch3 stay valid → ch2 is skipped, rr order 1,3,1,3; ch2 resumes fairly when it reasserts.
- CNT_W=2, ch1 matches 5 times with L=1 and pattern 1 → match_count sequence 1,2,3,3,3.
- cfg_we mid-stream after 2 of 3 bits on ch0 → in_ready=0 for 2 cycles (cfg cycle + CLEAR); fill resets, so 3 fresh bits are needed before a match. Reset asserted during RUN → all outputs return to 0 on the same edge.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the time-multiplexed sequence detector controller.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int PAT_MAX_DEF = 8;
  localparam int CNT_W_DEF   = 8;
  localparam int FILL_W_DEF  = $clog2(PAT_MAX_DEF + 1);

  // Per-channel match context at the default widths.
  typedef struct packed {
    logic [PAT_MAX_DEF-1:0] hist;
    logic [FILL_W_DEF-1:0]  fill;
    logic [CNT_W_DEF-1:0]   count;
  } ctx_t;

  // Length 0 behaves as 1; anything beyond the history depth is clamped.
  function automatic int eff_len(input int len, input int pat_max);
    if (len < 1) return 1;
    if (len > pat_max) return pat_max;
    return len;
  endfunction

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Per-channel serial handshake and match report bundle of seq_det_scheduler.
interface seq_det_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] in_bit;
  logic [NUM_CH-1:0] in_ready;
  logic              match_valid;
  logic [CH_W-1:0]   match_ch;
  logic [CNT_W-1:0]  match_count;

  modport master (
    output in_valid, in_bit,
    input  in_ready, match_valid, match_ch, match_count
  );

  modport slave (
    input  in_valid, in_bit,
    output in_ready, match_valid, match_ch, match_count
  );
endinterface

// File: rtl/seq_det_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module seq_det_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any_grant
);

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en && !any_grant && req[(int'(ptr) + i) % NUM_CH]) begin
        any_grant = 1'b1;
        idx       = IDX_W'((int'(ptr) + i) % NUM_CH);
        grant[(int'(ptr) + i) % NUM_CH] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Shares one serial pattern matcher across NUM_CH streams with per-channel contexts.
// Define SEQ_DET_OVERLAP_EN for overlapping detection; default is non-overlapping.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         cfg_we,
  input  logic [PAT_MAX-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
  seq_det_scheduler_if.slave           sio,
  output logic                         busy
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int LEN_W = $clog2(PAT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [PAT_MAX-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [CNT_W-1:0]   count;
  } ch_ctx_t;

  state_t             state;
  logic [CH_W-1:0]    rr_ptr;
  ch_ctx_t            ctx [NUM_CH];
  logic [PAT_MAX-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [PAT_MAX-1:0] len_mask;

  logic [NUM_CH-1:0]  grant;
  logic [CH_W-1:0]    gnt_idx;
  logic               any_grant;
  logic               arb_en;
  ch_ctx_t            cur;
  ch_ctx_t            nxt;
  logic               hit;

  // A configuration write wins over the grant in the same cycle.
  assign arb_en = (state == RUN) && !cfg_we;

  seq_det_rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(CH_W)) u_arb (
    .req       (sio.in_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (grant),
    .idx       (gnt_idx),
    .any_grant (any_grant)
  );

  assign sio.in_ready = grant;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) len_mask[i] = (i < int'(len));
  end

  always_comb begin
    cur      = ctx[gnt_idx];
    nxt      = cur;
    nxt.hist = {cur.hist[PAT_MAX-2:0], sio.in_bit[gnt_idx]};
    nxt.fill = (cur.fill == LEN_W'(PAT_MAX)) ? cur.fill : cur.fill + 1'b1;
    hit      = (nxt.fill >= len) && ((nxt.hist & len_mask) == (pattern & len_mask));
    if (hit) begin
      if (cur.count != CNT_MAX) nxt.count = cur.count + 1'b1;
`ifdef SEQ_DET_OVERLAP_EN
      nxt.fill = nxt.fill;
`else
      nxt.fill = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      rr_ptr          <= '0;
      pattern         <= '0;
      len             <= LEN_W'(1);
      sio.match_valid <= 1'b0;
      sio.match_ch    <= '0;
      sio.match_count <= '0;
      for (int i = 0; i < NUM_CH; i++) ctx[i] <= '0;
    end else begin
      sio.match_valid <= 1'b0;
      if (cfg_we) begin
        state   <= CLEAR;
        busy    <= 1'b0;
        pattern <= cfg_pattern;
        len     <= LEN_W'(eff_len(int'(cfg_len), PAT_MAX));
        for (int i = 0; i < NUM_CH; i++) ctx[i] <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (enable) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          CLEAR: begin
            for (int i = 0; i < NUM_CH; i++) ctx[i] <= '0;
            state <= enable ? RUN : IDLE;
            busy  <= enable;
          end
          RUN: begin
            if (any_grant) begin
              ctx[gnt_idx] <= nxt;
              rr_ptr       <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
              if (hit) begin
                sio.match_valid <= 1'b1;
                sio.match_ch    <= gnt_idx;
                sio.match_count <= nxt.count;
              end
            end
            if (!enable) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Scoreboard bench for seq_det_scheduler against a bit-list reference model.
module tb_seq_det_scheduler;

  localparam int N  = 4;
  localparam int PM = 8;
  localparam int CW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          cfg_we;
  logic [PM-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          busy;

  seq_det_scheduler_if #(.NUM_CH(N), .CNT_W(CW)) sio ();

  seq_det_scheduler #(.NUM_CH(N), .PAT_MAX(PM), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .sio         (sio.slave),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int strobes = 0;
  int last_count = 0;

  typedef struct {
    int c;
    int ch;
    int cnt;
  } exp_t;
  exp_t expq[$];
  exp_t e;

  typedef bit bitq_t[$];
  bitq_t         m_hist [N];
  int            m_cnt  [N];
  int            m_state;   // 0 idle, 1 run, 2 clear
  int            m_ptr;
  int            m_len;
  logic [PM-1:0] m_pat;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear_ctx();
    for (int i = 0; i < N; i++) begin
      m_hist[i].delete();
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ptr   = 0;
    m_len   = 1;
    m_pat   = '0;
    model_clear_ctx();
    expq.delete();
  endtask

  function automatic bit is_match(input int ch);
    int sz;
    sz = m_hist[ch].size();
    if (sz < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_hist[ch][sz-1-k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Predicts what the coming clock edge does from the inputs now applied.
  task automatic model_step();
    int g;
    int exp_ready;
    g = -1;
    if (m_state == 1 && !cfg_we)
      for (int i = 0; i < N; i++)
        if (g < 0 && sio.in_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
    exp_ready = (g >= 0) ? (1 << g) : 0;
    check("in_ready", int'(sio.in_ready), exp_ready);
    check("busy", int'(busy), (m_state == 1) ? 1 : 0);
    if (cfg_we) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > PM) ? PM : int'(cfg_len));
      model_clear_ctx();
      m_state = 2;
    end else begin
      case (m_state)
        0: if (enable) m_state = 1;
        2: begin
          model_clear_ctx();
          m_state = enable ? 1 : 0;
        end
        default: begin
          if (g >= 0) begin
            m_hist[g].push_back(sio.in_bit[g]);
            if (m_hist[g].size() > PM) void'(m_hist[g].pop_front());
            if (is_match(g)) begin
              if (m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;
              expq.push_back('{cyc + 1, g, m_cnt[g]});
`ifndef SEQ_DET_OVERLAP_EN
              m_hist[g].delete();
`endif
            end
            m_ptr = (g + 1) % N;
          end
          if (!enable) m_state = 0;
        end
      endcase
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) if (!reset) model_step();

  // Monitor: consumes every strobe the DUT presents.
  always @(negedge clk) begin
    if (!reset) begin
      if (sio.match_valid) begin
        strobes++;
        last_count = int'(sio.match_count);
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got ch=%0d count=%0d, expected no strobe (cycle %0d)",
                   sio.match_ch, sio.match_count, cyc);
        end else begin
          e = expq.pop_front();
          check("strobe_cycle", cyc, e.c);
          check("match_ch", int'(sio.match_ch), e.ch);
          check("match_count", int'(sio.match_count), e.cnt);
        end
      end else if (expq.size() > 0 && expq[0].c <= cyc) begin
        total++;
        bad++;
        $display("FAIL missed_strobe: got none, expected ch=%0d count=%0d at cycle %0d",
                 expq[0].ch, expq[0].cnt, expq[0].c);
        void'(expq.pop_front());
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] b, input logic en, input logic we);
    sio.in_valid = v;
    sio.in_bit   = b;
    enable       = en;
    cfg_we       = we;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [PM-1:0] p, input logic [LW-1:0] l);
    cfg_pattern = p;
    cfg_len     = l;
    drive('0, '0, 1'b1, 1'b1);
    drive('0, '0, 1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_match_valid"}, int'(sio.match_valid), 0);
    check({tag, "_match_ch"}, int'(sio.match_ch), 0);
    check({tag, "_match_count"}, int'(sio.match_count), 0);
    check({tag, "_in_ready"}, int'(sio.in_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  int s0;
  logic [3:0] bits5;
  logic [2:0] bits3;

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    cfg_we       = 1'b0;
    cfg_pattern  = '0;
    cfg_len      = '0;
    sio.in_valid = '0;
    sio.in_bit   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    sio.in_valid = '1;
    #1;
    check_outputs_zero("reset");
    sio.in_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Pattern 101, L=3 on ch0 alone.
    do_cfg(8'b101, 4'd3);
    s0 = strobes;
    for (int i = 0; i < 5; i++) drive(4'b0001, {3'b000, ~i[0]}, 1'b1, 1'b0);
    repeat (2) drive('0, '0, 1'b1, 1'b0);
`ifdef SEQ_DET_OVERLAP_EN
    check("stream_10101_strobes", strobes - s0, 2);
    check("stream_10101_last_count", last_count, 2);
`else
    check("stream_10101_strobes", strobes - s0, 1);
    check("stream_10101_last_count", last_count, 1);
`endif

    // Fresh rr order 0,1,2,3,... with every channel requesting.
    apply_reset();
    drive('0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      sio.in_valid = '1;
      sio.in_bit   = 4'($urandom);
      enable       = 1'b1;
      cfg_we       = 1'b0;
      #1;
      check("rr_all_valid_grant", int'(sio.in_ready), 1 << (k % 4));
      @(posedge clk);
      #1;
    end

    // ch2 drops out, then returns.
    for (int k = 0; k < 8; k++) drive(4'b1010, 4'($urandom), 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) drive(4'b1111, 4'($urandom), 1'b1, 1'b0);

    // Saturation with cfg_len=0 treated as length 1.
    do_cfg(8'h01, 4'd0);
    s0 = strobes;
    for (int k = 0; k < 260; k++) drive(4'b0010, 4'b0010, 1'b1, 1'b0);
    repeat (2) drive('0, '0, 1'b1, 1'b0);
    check("sat_strobes", strobes - s0, 260);
    check("sat_count", last_count, 255);

    // cfg_we after 2 of 3 bits: stream must restart.
    do_cfg(8'b101, 4'd3);
    drive(4'b0001, 4'b0001, 1'b1, 1'b0);
    drive(4'b0001, 4'b0000, 1'b1, 1'b0);
    cfg_pattern = 8'b101;
    cfg_len     = 4'd3;
    drive(4'b0001, 4'b0001, 1'b1, 1'b1);
    drive(4'b0001, 4'b0001, 1'b1, 1'b0);
    s0    = strobes;
    bits3 = 3'b101;
    for (int i = 2; i >= 0; i--) drive(4'b0001, {3'b000, bits3[i]}, 1'b1, 1'b0);
    repeat (2) drive('0, '0, 1'b1, 1'b0);
    check("restart_strobes", strobes - s0, 1);

    // Randomized traffic, enable drops, reconfiguration and clamped lengths.
    bits5 = '0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfg_pattern = 8'($urandom);
        cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
        drive(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
      end else begin
        drive(4'($urandom), 4'($urandom), ($urandom_range(0, 15) != 0), 1'b0);
      end
    end
    repeat (2) drive('0, '0, 1'b1, 1'b0);

    // Reset while a strobe is being presented.
    do_cfg(8'h01, 4'd1);
    drive(4'b1000, 4'b1000, 1'b1, 1'b0);
    check("pre_reset_strobe", int'(sio.match_valid), 1);
    check("pre_reset_ch", int'(sio.match_ch), 3);
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs_zero("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) drive(4'b1000, 4'b1000, 1'b0, 1'b0);
    check("drain_queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
